// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
//   NUM_REQ     : number of requesters feeding the FIFO
//   req_idx_t   : requester index type
//   arb_state_t : arbiter state encoding
package fifo_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority pick among four requesters
//   req   : request vector, bit i = requester i
//   last  : index of the most recent owner (lowest priority)
//   found : 1 when any req bit is set
//   index : first set req bit scanning upward from last+1, wrapping mod 4
module rr_pick4
    import fifo_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic               found,
    output req_idx_t           index
);

    req_idx_t cand;

    // Offsets 1..4 from last; offset 4 wraps back to last itself so the
    // previous owner is considered only after everyone else.
    always_comb begin
        found = 1'b0;
        index = last;
        cand  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + req_idx_t'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter with per-grant write quantum
//   clk, rst  : clock, asynchronous active-high reset
//   req, din  : per-requester write request and data slice
//   full      : full flag of the downstream FIFO
//   fifo_wr   : FIFO write enable, fifo_din : FIFO write data
//   gnt       : one-hot acknowledge of the requester written this edge
//   owner     : current owner index (valid when busy), busy : OWN or HOLD
//   wr_count  : wrapping count of accepted writes
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int QUANTUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    input  logic                      full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic [15:0]               wr_count
);

    localparam logic [4:0] QUANT_LAST = 5'(QUANTUM - 1);

    arb_state_t  state_q, state_d;
    req_idx_t    owner_q, owner_d;
    req_idx_t    last_owner_q, last_owner_d;
    logic [4:0]  quant_q, quant_d;
    logic [15:0] wr_count_q, wr_count_d;

    req_idx_t    pick_last;
    logic        pick_found;
    req_idx_t    pick_idx;
    logic        rel_now;

    // From IDLE the search starts after last_owner; on a release it starts
    // after the releasing owner, which becomes last_owner at the same edge.
    assign pick_last = (state_q == ST_IDLE) ? last_owner_q : owner_q;

    rr_pick4 u_pick (
        .req   (req),
        .last  (pick_last),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        fifo_wr  = (state_q == ST_OWN) && req[owner_q] && !full;
        gnt      = fifo_wr ? (NUM_REQ'(1) << owner_q) : '0;
        fifo_din = din[owner_q*DATA_W +: DATA_W];
    end

    assign busy     = (state_q != ST_IDLE);
    assign owner    = owner_q;
    assign wr_count = wr_count_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        quant_d      = quant_q;
        wr_count_d   = wr_count_q + (fifo_wr ? 16'd1 : 16'd0);
        rel_now      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_OWN;
                    owner_d = pick_idx;
                    quant_d = '0;
                end
            end
            ST_OWN: begin
                if (!req[owner_q]) begin
                    rel_now = 1'b1;
                end else if (full) begin
                    state_d = ST_HOLD;
                end else if (quant_q == QUANT_LAST) begin
                    rel_now = 1'b1;
                end else begin
                    quant_d = quant_q + 5'd1;
                end
            end
            ST_HOLD: begin
                if (!req[owner_q]) begin
                    rel_now = 1'b1;
                end else if (!full) begin
                    state_d = ST_OWN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handing over in the same edge avoids an idle bubble between bursts.
        if (rel_now) begin
            last_owner_d = owner_q;
            quant_d      = '0;
            if (pick_found) begin
                state_d = ST_OWN;
                owner_d = pick_idx;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            quant_q      <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            quant_q      <= quant_d;
            wr_count_q   <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        full;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] wr_count;

    int n_checks;
    int n_fail;

    logic [7:0] dval [4];

    fifo_wr_arbiter #(.DATA_W(8), .QUANTUM(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .full     (full),
        .fifo_wr  (fifo_wr),
        .fifo_din (fifo_din),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        full = 1'b0;
        #2;
        n_checks++;
        if (fifo_wr !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr=%b gnt=%b busy=%b, expected 0 0000 0", fifo_wr, gnt, busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wr_count !== 16'd0 || owner !== 2'd0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d owner=%0d busy=%b gnt=%b, expected 0 0 0 0000",
                     wr_count, owner, busy, gnt);
        end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        #1;
        n_checks++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cycle0: busy=%b wr=%b, expected 0 0", busy, fifo_wr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || gnt !== 4'b0001 || fifo_din !== 8'hA5 || owner !== 2'd0 || fifo_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cycle1: busy=%b gnt=%b din=%h owner=%0d wr=%b, expected 1 0001 a5 0 1",
                     busy, gnt, fifo_din, owner, fifo_wr);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        #1;
        n_checks++;
        if (fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle_write: wr=%b, expected 0", fifo_wr);
        end
        for (int k = 1; k <= 20; k++) begin
            int idx;
            logic [3:0] eg;
            @(negedge clk);
            #1;
            idx = ((k - 1) / 4) % 4;
            eg  = 4'b0001 << idx;
            n_checks++;
            if (gnt !== eg || fifo_din !== dval[idx]) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: gnt=%b din=%h, expected %b %h", k, gnt, fifo_din, eg, dval[idx]);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (wr_count !== 16'd20) begin
            n_fail++;
            $display("FAIL rr_count: wr_count=%0d, expected 20", wr_count);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_g [9];
        exp_g = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0010, 4'b0010, 4'b0001};
        do_reset();
        req = 4'b0010;
        #1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            req  = 4'b0011;
            full = (c >= 3 && c <= 5);
            #1;
            n_checks++;
            if (gnt !== exp_g[c-1] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: gnt=%b busy=%b, expected %b 1", c, gnt, busy, exp_g[c-1]);
            end
        end
        full = 1'b0;
    endtask

    task automatic test_release_idle();
        do_reset();
        req = 4'b0100;
        #1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (gnt !== 4'b0100 || fifo_din !== 8'hC2) begin
                n_fail++;
                $display("FAIL rel_write%0d: gnt=%b din=%h, expected 0100 c2", c, gnt, fifo_din);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_drop: wr=%b, expected 0", fifo_wr);
        end
        @(negedge clk);
        req = 4'b0101;
        #1;
        n_checks++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_idle: busy=%b wr=%b, expected 0 0", busy, fifo_wr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL rel_regrant: gnt=%b owner=%0d, expected 0001 0", gnt, owner);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (gnt !== 4'b1000 || fifo_din !== 8'hD3 || wr_count !== 16'(c - 1)) begin
                n_fail++;
                $display("FAIL ares_burst%0d: gnt=%b din=%h count=%0d, expected 1000 d3 %0d",
                         c, gnt, fifo_din, wr_count, c - 1);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (fifo_wr !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL ares_immediate: wr=%b gnt=%b busy=%b count=%0d, expected 0 0000 0 0",
                     fifo_wr, gnt, busy, wr_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ares_idle: busy=%b, expected 0", busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL ares_first: gnt=%b owner=%0d, expected 0001 0", gnt, owner);
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (wr_count !== 16'hFFFF || fifo_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_preset: count=%h wr=%b, expected ffff 1", wr_count, fifo_wr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wr_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: count=%h, expected 0000", wr_count);
        end
        req = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        dval     = '{8'hA5, 8'hB1, 8'hC2, 8'hD3};
        din      = {dval[3], dval[2], dval[1], dval[0]};
        rst      = 1'b1;
        req      = 4'b0000;
        full     = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_release_idle();
        test_async_reset();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester data bus and of fifo_din.
REQ-002 SHALL have parameter QUANTUM, default 4, maximum consecutive writes per grant (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  4  per-requester write request, bit i = requester i.
REQ-006 SHALL have port din  input  4*DATA_W  requester data, slice i = din[i*DATA_W +: DATA_W].
REQ-007 SHALL have port full  input  1  FIFO full flag, combinational from the FIFO being fed.
REQ-008 SHALL have port fifo_wr  output  1  FIFO write enable.
REQ-009 SHALL have port fifo_din  output  DATA_W  FIFO write data.
REQ-010 SHALL have port gnt  output  4  one-hot write acknowledge; gnt[i]=1 means din slice i is written at this edge.
REQ-011 SHALL have port owner  output  2  index of current owner, valid when busy=1.
REQ-012 SHALL have port busy  output  1  1 when state is OWN or HOLD.
REQ-013 SHALL have port wr_count  output  16  total accepted writes, wraps 0xFFFF->0.

Function
REQ-014 SHALL implement states IDLE, OWN, HOLD; registered state, owner, last_owner, quantum counter.
REQ-015 SHALL, in IDLE with any req bit set, move at the next edge to OWN with owner = first set req bit scanning from last_owner+1 mod 4 upward, quantum counter = 0.
REQ-016 SHALL never write in IDLE; first gnt follows a req from IDLE after exactly one cycle.
REQ-017 SHALL drive fifo_wr = (state==OWN) & req[owner] & ~full combinationally; gnt = fifo_wr ? one-hot(owner) : 0; fifo_din = din slice owner.
REQ-018 SHALL increment the quantum counter on each write in OWN; the write that reaches QUANTUM releases ownership.
REQ-019 SHALL release ownership in OWN when req[owner]=0.
REQ-020 SHALL, on release, set last_owner=owner and re-arbitrate in the same edge per REQ-015 (the releasing owner is eligible only if no other req is set), entering OWN with no bubble, or IDLE if req==0.
REQ-021 SHALL move OWN->HOLD when req[owner]=1 and full=1; no write, quantum counter unchanged.
REQ-022 SHALL move HOLD->OWN at the first edge with full=0; fifo_wr=0 throughout HOLD, so writes resume one cycle after full falls.
REQ-023 SHALL release from HOLD per REQ-020 if req[owner] drops while in HOLD.
REQ-024 SHALL increment wr_count at every edge where fifo_wr=1.
REQ-025 SHALL ignore data on non-owner requesters; they are never acknowledged.

Reset
REQ-026 SHALL on rst=1 immediately force state=IDLE, last_owner=3 (requester 0 wins first), quantum=0, owner=0, wr_count=0.
REQ-027 SHALL hold fifo_wr=0, gnt=0, busy=0 while rst=1, including reset asserted mid-burst or in HOLD.

Structure
REQ-028 SHALL take state encoding, NUM_REQ=4 and the 2-bit index type from shared package fifo_arb_pkg.
REQ-029 SHALL place the rotating-priority search in combinational sub-module rr_pick4 (inputs req, last index; outputs found, index).

Verification
REQ-030 Reset then req=0001, din0=0xA5, full=0 -> busy at cycle 1, gnt=0001 and fifo_din=0xA5 from cycle 1, owner=0.
REQ-031 req=1111 held, full=0 -> bursts of 4 writes in order 0,1,2,3,0, no idle cycle between bursts, wr_count=20 after 20 cycles.
REQ-032 Owner 1 writing, full=1 for 3 cycles -> fifo_wr=0 for those 3 cycles plus one, then writes resume; quantum count continues, not reset.
REQ-033 req=0100 for 2 writes then req=0000 -> release to IDLE, last_owner=2; next req=0101 -> requester 0 granted first.
REQ-034 rst asserted asynchronously mid-burst of requester 3 -> fifo_wr, gnt, busy, wr_count zero before next edge; after release, req=1000|0001 -> requester 0 first.
REQ-035 wr_count preset by 65535 writes, one more write -> wr_count=0.
